div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Sequencer between the execute stage and the multi-cycle restoring divider.
- Accepts DIV/DIVU/REM/REMU requests through a valid/ready handshake.
- Converts signed operands to magnitudes, launches the unsigned divider, and waits for its quotient.
- Derives the remainder, applies sign correction, and holds the result for writeback under backpressure.
- Resolves divide-by-zero and signed overflow locally, without starting the divider.

Parameters:
WIDTH, 32, operand/result width; must equal the divider's width parameter.
TAG_W, 5, destination-register tag width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  block can accept a request
req_op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
req_a_i  in  WIDTH  dividend
req_b_i  in  WIDTH  divisor
req_tag_i  in  TAG_W  destination tag
flush_i  in  1  abort the in-flight request
rsp_valid_o  out  1  result present
rsp_ready_i  in  1  writeback accepts result
rsp_data_o  out  WIDTH  result
rsp_tag_o  out  TAG_W  tag of result
div_start_o  out  1  one-cycle start pulse to divider
div_dividend_o  out  WIDTH  unsigned dividend to divider
div_divisor_o  out  WIDTH  unsigned divisor to divider (never 0 while div_start_o=1)
div_busy_i  in  1  divider busy
div_valid_i  in  1  divider one-cycle completion pulse
div_quotient_i  in  WIDTH  divider quotient

Behaviour:
- Reset values: state IDLE; req_ready_o=1; rsp_valid_o=0; div_start_o=0; rsp_data_o, rsp_tag_o, div_dividend_o and div_divisor_o all 0.
- Reset mid-operation returns the block to IDLE. The divider is reset on the same rst_i.
- Acceptance happens when req_valid_i && req_ready_o. req_ready_o=1 only in IDLE.
- On acceptance the block latches op, tag, raw a and raw b. It computes |a| and |b| as two's-complement negation when the op is signed and the MSB is set; otherwise the raw value is used.
- It records neg_q = signed && (a_msb ^ b_msb) and neg_r = signed && a_msb.
- States:
  - IDLE:
    - Accept a request with b==0 -> RESP, data = all-ones (DIV/DIVU) or raw a (REM/REMU).
    - Accept a signed request with a==MIN and b==all-ones -> RESP, data = MIN (DIV) or 0 (REM).
    - Accept any other request -> LAUNCH.
  - LAUNCH: div_start_o=1 for exactly this cycle, with div_dividend_o=|a| and div_divisor_o=|b| stable. Go to WAIT.
  - WAIT: on div_valid_i, capture div_quotient_i and go to FIX. div_valid_i arriving in the LAUNCH cycle is ignored.
  - FIX (1 cycle):
    - rem = |a| - q*|b|, low WIDTH bits only.
    - DIV/DIVU result = neg_q ? -q : q.
    - REM/REMU result = neg_r ? -rem : rem.
    - Register the result into rsp_data_o, then go to RESP.
  - RESP: rsp_valid_o=1, and data/tag hold stable until rsp_ready_i. On rsp_ready_i go to IDLE. A new request is accepted no earlier than the cycle after the handshake.
  - DRAIN: the divider cannot be aborted. Wait for div_valid_i, discard the quotient, and go to IDLE. rsp_valid_o=0.
- Flush:
  - In LAUNCH or WAIT -> DRAIN.
  - In FIX or RESP -> IDLE, and the result is dropped.
  - In IDLE: no effect, and a request in the same cycle is not accepted.
- Latency for a normal path: accept at cycle 0, start pulse at cycle 1, FIX one cycle after div_valid_i, rsp_valid_o the cycle after that. Bypass path: rsp_valid_o at cycle 1.
- div_busy_i is used only by an assertion: it must not be 1 in IDLE.
- Arithmetic: all WIDTH-bit modulo. The product q*|b| is truncated to WIDTH bits.

Decomposition:
- Package div_pkg holds:
  - div_op_e enum: DIV, DIVU, REM, REMU.
  - div_state_e enum: IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
  - Helper function is_signed(op).
- One combinational sub-module, div_sign_fix: magnitude conversion on input, and remainder plus sign correction on output.
- The FSM and registers stay in div_issue_ctrl.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> rsp_data=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). Exactly one div_start_o pulse each.
- DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2. Tags 5'd3 and 5'd9 echoed on rsp_tag_o.
- DIV a=5, b=0 -> 0xFFFFFFFF at cycle 1. REM a=5, b=0 -> 5. div_start_o never asserted.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Both on the bypass path, no divider start.
- Backpressure: rsp_ready_i held low 3 cycles after rsp_valid_o -> data/tag stable, req_ready_o=0. Completes when ready rises.
- Flush in WAIT -> no rsp_valid_o, req_ready_o=0 until div_valid_i is seen. The next request (DIVU 9/3) returns 3. rst_i asserted during WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the divide issue controller.
//   div_op_e    : request opcode encoding (matches req_op_i)
//   div_state_e : controller FSM states
//   is_signed() : opcode is a signed operation (DIV/REM)
//   is_rem()    : opcode returns the remainder (REM/REMU)
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FIX    = 3'd3,
    RESP   = 3'd4,
    DRAIN  = 3'd5
  } div_state_e;

  function automatic logic is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned divider.
// Input side : converts raw operands to magnitudes and derives the
//              result-negation flags.
//   op, a, b            -> mag_a, mag_b, neg_q, neg_r
// Output side: rebuilds the remainder from the quotient and applies the
//              recorded sign correction.
//   fix_is_rem, fix_mag_a, fix_mag_b, fix_neg_q, fix_neg_r, quotient
//                       -> result
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg_q,
  output logic             neg_r,
  input  logic             fix_is_rem,
  input  logic [WIDTH-1:0] fix_mag_a,
  input  logic [WIDTH-1:0] fix_mag_b,
  input  logic             fix_neg_q,
  input  logic             fix_neg_r,
  input  logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] result
);

  logic             sgn;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] rem;

  assign sgn   = is_signed(div_op_e'(op));
  assign mag_a = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign neg_q = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
  assign neg_r = sgn && a[WIDTH-1];

  // The divider only returns the quotient, so the remainder is rebuilt
  // here; modulo-2^WIDTH arithmetic is exact because rem < |b|.
  assign prod = quotient * fix_mag_b;
  assign rem  = fix_mag_a - prod;

  always_comb begin
    result = '0;
    if (fix_is_rem) result = fix_neg_r ? (~rem + 1'b1) : rem;
    else            result = fix_neg_q ? (~quotient + 1'b1) : quotient;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer between execute and the multi-cycle unsigned divider.
// Accepts DIV/DIVU/REM/REMU over a valid/ready handshake, resolves
// divide-by-zero and signed overflow locally, otherwise launches the
// divider on operand magnitudes, sign-corrects its quotient/remainder and
// holds the result until writeback accepts it.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           request handshake
//   req_op_i, req_a_i, req_b_i, req_tag_i  request payload
//   flush_i                           abort the in-flight request
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_data_o, rsp_tag_o             response payload
//   div_start_o, div_dividend_o, div_divisor_o  divider launch
//   div_busy_i, div_valid_i, div_quotient_i     divider status/result
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             div_start_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic             div_busy_i,
  input  logic             div_valid_i,
  input  logic [WIDTH-1:0] div_quotient_i
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_reg, state_next;
  logic             is_rem_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [WIDTH-1:0] mag_a_reg, mag_b_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] rsp_data_reg;

  div_op_e          req_op;
  logic             accept;
  logic             b_zero;
  logic             ovf;
  logic             bypass;
  logic [WIDTH-1:0] bypass_data;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] fix_result;

  assign req_op = div_op_e'(req_op_i);

  // A flush in IDLE blocks acceptance even though ready is high.
  assign accept = req_valid_i && req_ready_o && !flush_i;
  assign b_zero = (req_b_i == '0);
  assign ovf    = is_signed(req_op) && (req_a_i == MIN_VAL) && (req_b_i == '1);
  assign bypass = b_zero || ovf;

  always_comb begin
    bypass_data = '0;
    if (b_zero) bypass_data = is_rem(req_op) ? req_a_i : '1;
    else        bypass_data = is_rem(req_op) ? '0 : MIN_VAL;
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op         (req_op_i),
    .a          (req_a_i),
    .b          (req_b_i),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg_q      (neg_q),
    .neg_r      (neg_r),
    .fix_is_rem (is_rem_reg),
    .fix_mag_a  (mag_a_reg),
    .fix_mag_b  (mag_b_reg),
    .fix_neg_q  (neg_q_reg),
    .fix_neg_r  (neg_r_reg),
    .quotient   (q_reg),
    .result     (fix_result)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = bypass ? RESP : LAUNCH;
      LAUNCH: state_next = flush_i ? DRAIN : WAIT;
      WAIT: begin
        // Flush coinciding with completion: nothing is left to drain.
        if (flush_i)          state_next = div_valid_i ? IDLE : DRAIN;
        else if (div_valid_i) state_next = FIX;
      end
      FIX:    state_next = flush_i ? IDLE : RESP;
      RESP:   if (flush_i || rsp_ready_i) state_next = IDLE;
      DRAIN:  if (div_valid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      is_rem_reg   <= 1'b0;
      tag_reg      <= '0;
      mag_a_reg    <= '0;
      mag_b_reg    <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      q_reg        <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        is_rem_reg <= is_rem(req_op);
        tag_reg    <= req_tag_i;
        mag_a_reg  <= mag_a;
        mag_b_reg  <= mag_b;
        neg_q_reg  <= neg_q;
        neg_r_reg  <= neg_r;
        if (bypass) rsp_data_reg <= bypass_data;
      end
      if (state_reg == WAIT && div_valid_i) q_reg <= div_quotient_i;
      if (state_reg == FIX) rsp_data_reg <= fix_result;
    end
  end

  assign req_ready_o    = (state_reg == IDLE);
  assign rsp_valid_o    = (state_reg == RESP);
  assign rsp_data_o     = rsp_data_reg;
  assign rsp_tag_o      = tag_reg;
  assign div_start_o    = (state_reg == LAUNCH);
  assign div_dividend_o = mag_a_reg;
  assign div_divisor_o  = mag_b_reg;

  // The divider must be quiet whenever no operation is outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_reg == IDLE) begin
      assert (!div_busy_i) else $error("div_issue_ctrl: divider busy while IDLE");
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready_o;
  logic [1:0]    req_op;
  logic [W-1:0]  req_a, req_b;
  logic [TW-1:0] req_tag;
  logic          flush;
  logic          rsp_valid_o;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data_o;
  logic [TW-1:0] rsp_tag_o;
  logic          div_start_o;
  logic [W-1:0]  div_dividend_o, div_divisor_o;
  logic          div_busy, div_valid;
  logic [W-1:0]  div_quotient;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_tag_i      (req_tag),
    .flush_i        (flush),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data_o),
    .rsp_tag_o      (rsp_tag_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_busy_i     (div_busy),
    .div_valid_i    (div_valid),
    .div_quotient_i (div_quotient)
  );

  // Behavioural unsigned divider: valid pulse four cycles after start.
  logic [2:0]   m_cnt;
  logic [W-1:0] m_q;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt        <= '0;
      m_q          <= '0;
      div_busy     <= 1'b0;
      div_valid    <= 1'b0;
      div_quotient <= '0;
    end else begin
      div_valid <= 1'b0;
      if (div_start_o) begin
        start_cnt <= start_cnt + 1;
        m_q       <= (div_divisor_o == '0) ? '1 : div_dividend_o / div_divisor_o;
        m_cnt     <= 3'd3;
        div_busy  <= 1'b1;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1'b1;
        if (m_cnt == 3'd1) begin
          div_valid    <= 1'b1;
          div_quotient <= m_q;
          div_busy     <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and follow it to completion.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input bit byp, input int hold);
    int s0, cyc, start_cyc, dv_cyc, rsp_cyc;
    s0 = start_cnt; start_cyc = -1; dv_cyc = -1;
    check({name, "_ready"}, 32'(req_ready_o), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (rsp_valid_o !== 1'b1 && cyc < 60) begin
      if (div_start_o === 1'b1 && start_cyc < 0) start_cyc = cyc;
      if (div_valid === 1'b1 && dv_cyc < 0) dv_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    rsp_cyc = (rsp_valid_o === 1'b1) ? cyc : -1;
    check({name, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    if (byp) begin
      check({name, "_bypass_lat"}, 32'(rsp_cyc), 32'd1);
      check({name, "_starts"}, 32'(start_cnt - s0), 32'd0);
    end else begin
      check({name, "_start_cyc"}, 32'(start_cyc), 32'd1);
      check({name, "_fix_lat"}, 32'(rsp_cyc), 32'(dv_cyc + 2));
      check({name, "_starts"}, 32'(start_cnt - s0), 32'd1);
    end
    check({name, "_data"}, rsp_data_o, exp);
    check({name, "_tag"}, 32'(rsp_tag_o), 32'(tag));
    check({name, "_busy_ready"}, 32'(req_ready_o), 32'd0);
    $display("txn %s op=%0d a=0x%08h b=0x%08h tag=%0d data=0x%08h exp=0x%08h",
             name, op, a, b, tag, rsp_data_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
      check({name, "_hold_data"}, rsp_data_o, exp);
      check({name, "_hold_tag"}, 32'(rsp_tag_o), 32'(tag));
      check({name, "_hold_ready"}, 32'(req_ready_o), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({name, "_done_valid"}, 32'(rsp_valid_o), 32'd0);
    check({name, "_done_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_tag = '0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_start", 32'(div_start_o), 32'd0);
    check("rst_data", rsp_data_o, 32'd0);
    check("rst_tag", 32'(rsp_tag_o), 32'd0);
    check("rst_dividend", div_dividend_o, 32'd0);
    check("rst_divisor", div_divisor_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("div_neg",  2'd0, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 1'b0, 0);
    do_op("rem_neg",  2'd2, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 1'b0, 0);
    do_op("divu",     2'd1, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 0);
    do_op("remu",     2'd3, 32'd100, 32'd7, 5'd9, 32'd2, 1'b0, 0);
    do_op("div_z",    2'd0, 32'd5, 32'd0, 5'd4, 32'hFFFFFFFF, 1'b1, 0);
    do_op("rem_z",    2'd2, 32'd5, 32'd0, 5'd5, 32'd5, 1'b1, 0);
    do_op("div_ovf",  2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, 1'b1, 0);
    do_op("rem_ovf",  2'd2, 32'h80000000, 32'hFFFFFFFF, 5'd7, 32'd0, 1'b1, 0);
    do_op("div_mixed", 2'd0, 32'd20, 32'hFFFFFFFA, 5'd8, 32'hFFFFFFFD, 1'b0, 0);
    do_op("bp_divu",  2'd1, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 3);

    // Flush while IDLE with a request present: must not be accepted.
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd9; req_b = 32'd3; req_tag = 5'd1;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_start", 32'(div_start_o), 32'd0);
    check("idle_flush_ready", 32'(req_ready_o), 32'd1);
    $display("txn idle_flush start=%0d ready=%0d", div_start_o, req_ready_o);

    // Flush in WAIT: drain the divider, no response.
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd1000; req_b = 32'd10; req_tag = 5'd11;
    @(negedge clk);
    req_valid = 1'b0;
    check("fl_start", 32'(div_start_o), 32'd1);
    check("fl_dividend", div_dividend_o, 32'd1000);
    check("fl_divisor", div_divisor_o, 32'd10);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      check("fl_no_valid", 32'(rsp_valid_o), 32'd0);
      check("fl_not_ready", 32'(req_ready_o), 32'd0);
      if (div_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("fl_div_valid_seen", 32'(seen), 32'd1);
    check("fl_ready_after", 32'(req_ready_o), 32'd1);
    check("fl_valid_after", 32'(rsp_valid_o), 32'd0);
    $display("txn flush_wait drained=%0d ready=%0d", seen, req_ready_o);
    do_op("after_fl", 2'd1, 32'd9, 32'd3, 5'd12, 32'd3, 1'b0, 0);

    // Reset while WAIT.
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ready", 32'(req_ready_o), 32'd1);
    check("mrst_valid", 32'(rsp_valid_o), 32'd0);
    check("mrst_start", 32'(div_start_o), 32'd0);
    check("mrst_data", rsp_data_o, 32'd0);
    check("mrst_tag", 32'(rsp_tag_o), 32'd0);
    check("mrst_dividend", div_dividend_o, 32'd0);
    check("mrst_divisor", div_divisor_o, 32'd0);
    $display("txn reset_wait ready=%0d valid=%0d", req_ready_o, rsp_valid_o);
    rst = 1'b0;
    @(negedge clk);
    do_op("after_rst", 2'd3, 32'd23, 32'd5, 5'd14, 32'd3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
